// File: rtl/usbfs_packet_rx.sv
// USB Full Speed packet receiver: assembles PID, token fields and data payload
// from unstuffed bits, checks PID/CRC5/CRC16 and reports one status per packet.
module usbfs_packet_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_sta,
    input  logic       rx_ena,
    input  logic       rx_bit,
    input  logic       rx_fin,
    output logic       rp_byte_en,
    output logic [7:0] rp_byte,
    output logic       rp_fin,
    output logic       rp_okay,
    output logic [3:0] rp_pid,
    output logic [6:0] rp_addr,
    output logic [3:0] rp_endp,
    output logic [6:0] rp_len
);
    typedef enum logic [1:0] {ST_IDLE, ST_PID, ST_BODY} state_t;

    localparam logic [1:0] CLS_TOKEN = 2'b01;
    localparam logic [1:0] CLS_HSK   = 2'b10;
    localparam logic [1:0] CLS_DATA  = 2'b11;

    state_t      state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  body_bytes_q, body_bytes_d;
    logic [7:0]  dl0_q, dl0_d, dl1_q, dl1_d;
    logic [1:0]  dl_cnt_q, dl_cnt_d;
    logic [6:0]  len_q, len_d;
    logic [3:0]  pid_q, pid_d;
    logic        pid_ok_q, pid_ok_d;
    logic [10:0] tok_q, tok_d;
    logic [4:0]  crc5_q, crc5_d;
    logic [15:0] crc16_q, crc16_d;

    logic        byte_en_d, fin_d, okay_d;
    logic [7:0]  byte_d;
    logic [3:0]  out_pid_d, endp_d;
    logic [6:0]  addr_d, out_len_d;

    logic [7:0]  sr_nxt;
    logic        byte_done, tok_open, cls_ok;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        body_bytes_d = body_bytes_q;
        dl0_d        = dl0_q;
        dl1_d        = dl1_q;
        dl_cnt_d     = dl_cnt_q;
        len_d        = len_q;
        pid_d        = pid_q;
        pid_ok_d     = pid_ok_q;
        tok_d        = tok_q;
        crc5_d       = crc5_q;
        crc16_d      = crc16_q;
        byte_en_d    = 1'b0;
        byte_d       = rp_byte;
        fin_d        = 1'b0;
        okay_d       = 1'b0;
        out_pid_d    = rp_pid;
        addr_d       = rp_addr;
        endp_d       = rp_endp;
        out_len_d    = rp_len;
        cls_ok       = 1'b0;
        sr_nxt       = {rx_bit, sr_q[7:1]};
        byte_done    = (bit_cnt_q == 3'd7);
        tok_open     = (body_bytes_q == 7'd0) ||
                       ((body_bytes_q == 7'd1) && (bit_cnt_q < 3'd3));

        if (rx_sta) begin
            state_d      = ST_PID;
            sr_d         = '0;
            bit_cnt_d    = '0;
            body_bytes_d = '0;
            dl0_d        = '0;
            dl1_d        = '0;
            dl_cnt_d     = '0;
            len_d        = '0;
            pid_d        = '0;
            pid_ok_d     = 1'b0;
            tok_d        = '0;
            crc5_d       = '1;
            crc16_d      = '1;
        end else if (state_q != ST_IDLE) begin
            if (rx_ena) begin
                sr_d      = sr_nxt;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (state_q == ST_PID) begin
                    if (byte_done) begin
                        pid_d    = sr_nxt[3:0];
                        pid_ok_d = (sr_nxt[7:4] == ~sr_nxt[3:0]);
                        state_d  = ST_BODY;
                    end
                end else begin
                    if (pid_q[1:0] == CLS_TOKEN) begin
                        crc5_d = {crc5_q[3:0], 1'b0} ^ ({5{crc5_q[4] ^ rx_bit}} & 5'h05);
                        if (tok_open)
                            tok_d = {rx_bit, tok_q[10:1]};
                    end
                    if (pid_q[1:0] == CLS_DATA)
                        crc16_d = {crc16_q[14:0], 1'b0} ^ ({16{crc16_q[15] ^ rx_bit}} & 16'h8005);
                    if (byte_done) begin
                        if (body_bytes_q != 7'h7F)
                            body_bytes_d = body_bytes_q + 7'd1;
                        // Two-byte lag keeps the trailing CRC16 off the payload strobe
                        if (pid_q[1:0] == CLS_DATA) begin
                            if (dl_cnt_q == 2'd2) begin
                                byte_en_d = 1'b1;
                                byte_d    = dl0_q;
                                dl0_d     = dl1_q;
                                dl1_d     = sr_nxt;
                                if (len_q != 7'h7F)
                                    len_d = len_q + 7'd1;
                            end else if (dl_cnt_q == 2'd1) begin
                                dl1_d    = sr_nxt;
                                dl_cnt_d = 2'd2;
                            end else begin
                                dl0_d    = sr_nxt;
                                dl_cnt_d = 2'd1;
                            end
                        end
                    end
                end
            end
            if (rx_fin) begin
                case (pid_d[1:0])
                    CLS_TOKEN: cls_ok = (body_bytes_d == 7'd2) && (crc5_d == 5'b01100);
                    CLS_DATA:  cls_ok = (body_bytes_d >= 7'd2) && (crc16_d == 16'h800D);
                    CLS_HSK:   cls_ok = (body_bytes_d == 7'd0);
                    default:   cls_ok = 1'b0;
                endcase
                okay_d    = (state_d == ST_BODY) && pid_ok_d && (bit_cnt_d == 3'd0) && cls_ok;
                fin_d     = 1'b1;
                out_pid_d = pid_d;
                addr_d    = tok_d[6:0];
                endp_d    = tok_d[10:7];
                out_len_d = len_d;
                state_d   = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            body_bytes_q <= '0;
            dl0_q        <= '0;
            dl1_q        <= '0;
            dl_cnt_q     <= '0;
            len_q        <= '0;
            pid_q        <= '0;
            pid_ok_q     <= 1'b0;
            tok_q        <= '0;
            crc5_q       <= '1;
            crc16_q      <= '1;
            rp_byte_en   <= 1'b0;
            rp_byte      <= '0;
            rp_fin       <= 1'b0;
            rp_okay      <= 1'b0;
            rp_pid       <= '0;
            rp_addr      <= '0;
            rp_endp      <= '0;
            rp_len       <= '0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            body_bytes_q <= body_bytes_d;
            dl0_q        <= dl0_d;
            dl1_q        <= dl1_d;
            dl_cnt_q     <= dl_cnt_d;
            len_q        <= len_d;
            pid_q        <= pid_d;
            pid_ok_q     <= pid_ok_d;
            tok_q        <= tok_d;
            crc5_q       <= crc5_d;
            crc16_q      <= crc16_d;
            rp_byte_en   <= byte_en_d;
            rp_byte      <= byte_d;
            rp_fin       <= fin_d;
            rp_okay      <= okay_d;
            rp_pid       <= out_pid_d;
            rp_addr      <= addr_d;
            rp_endp      <= endp_d;
            rp_len       <= out_len_d;
        end
    end
endmodule

// File: doc/usbfs_packet_rx.md
# usbfs_packet_rx

USB Full Speed (12 Mbps) device packet receiver, and the RX counterpart of the packet sender. It sits between the bit-level receiver and the transaction controller. The bit-level receiver does NRZI decoding, SYNC detection and bit unstuffing. This block collects LSB-first bits into PID, token fields and data bytes. It checks the PID complement, CRC5 on tokens and CRC16 on data packets. It strips the CRC bytes and reports one status pulse per packet.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  — 60 MHz system clock, single clock domain.
- `rst`  in  1  — reset. Synchronous and active-high.
- `rx_sta`  in  1  — one-cycle pulse: a new packet starts (SYNC already consumed).
- `rx_ena`  in  1  — `rx_bit` is valid this cycle (one unstuffed bit).
- `rx_bit`  in  1  — received bit, LSB of each byte first.
- `rx_fin`  in  1  — one-cycle pulse: EOP seen, packet ended.
- `rp_byte_en`  out  1  — one-cycle strobe: `rp_byte` carries a data-payload byte.
- `rp_byte`  out  8  — payload byte (data packets only; CRC16 bytes never output).
- `rp_fin`  out  1  — one-cycle pulse: packet complete, fields below are valid.
- `rp_okay`  out  1  — with `rp_fin`: 1 means packet well-formed and CRC good.
- `rp_pid`  out  4  — low nibble of the PID byte.
- `rp_addr`  out  7  — token address; bits [6:0] of the 11-bit token field.
- `rp_endp`  out  4  — token endpoint; bits [10:7] of the token field.
- `rp_len`  out  7  — payload byte count, saturating at 127.

## Operation
- States: IDLE, PID, BODY.
- Any state, `rx_sta`=1: clear bit counter, byte count, 2-byte delay line and shift register. Set crc5=5'h1F and crc16=16'hFFFF. Go to PID. This abandons any packet in progress; no `rp_fin` is generated for it.
- Bits are shifted in LSB-first. A byte is complete after 8 `rx_ena` cycles.
- PID state:
  - After 8 bits, latch the PID byte and go to BODY.
  - `pid_ok` = (byte[7:4] == ~byte[3:0]).
- Packet class is decided by PID[1:0]:
  - 01 = token (OUT/IN/SOF/SETUP).
  - 11 = data.
  - 10 = handshake.
  - 00 = special.
- Token body: feed all 16 bits into CRC5 (poly x^5+x^2+1, MSB-first shift, xor = crc[4]^bit). Capture the first 11 bits as {endp, addr}.
- Data body: feed every bit into CRC16 with the same update as the sender: crc = {crc[14:0],0} ^ ({16{crc[15]^bit}} & 16'h8005).
- Data byte delay line:
  - Each completed byte enters a 2-deep delay line.
  - When a byte arrives and the line already holds 2 bytes, the oldest byte is emitted on `rp_byte`/`rp_byte_en`, and `rp_len` increments.
  - The 2 bytes left in the line at EOP are the CRC and are discarded.
- On `rx_fin` in BODY or PID: pulse `rp_fin` and return to IDLE. `rp_okay`=1 iff all of the following hold:
  - `pid_ok`.
  - Bit count is a multiple of 8.
  - Token: exactly 16 body bits and crc5 residual == 5'b01100.
  - Data: at least 16 body bits and crc16 residual == 16'h800D.
  - Handshake: 0 body bits.
  - Special PID: `rp_okay`=0.
- `rx_fin` in IDLE is ignored.
- `rx_ena` in IDLE is ignored.
- Bytes already emitted are not retracted. The consumer discards payload when `rp_okay`=0.
- Body longer than 66 bytes: payload is still emitted and `rp_len` saturates. `rp_okay` follows the CRC only.

## Timing
- Reset values:
  - `rp_byte_en`, `rp_fin`, `rp_okay` = 0.
  - `rp_byte`, `rp_pid`, `rp_addr`, `rp_endp`, `rp_len` = 0.
  - State = IDLE.
- `rp_byte_en` is asserted the cycle after the `rx_ena` that completes a byte, whenever 2 bytes were already buffered.
- `rp_fin` is asserted the cycle after `rx_fin`, together with `rp_okay`.
- `rp_pid`, `rp_addr`, `rp_endp`, `rp_len` are registered. They hold their values until the next `rp_fin`.
- `rx_fin` and `rx_ena` in the same cycle: the bit is consumed first, then the end check is made on the updated state.
- `rx_sta` and `rx_fin` in the same cycle: `rx_sta` wins; no `rp_fin`.
- `rst` mid-packet: outputs clear next cycle, no `rp_fin`, subsequent bits are ignored until `rx_sta`.
- `rx_ena` may be asserted back-to-back or sparsely. Behaviour depends only on the count of `rx_ena` cycles.

## Test plan
- ACK bytes D2 → one `rp_fin` with `rp_okay`=1, `rp_pid`=2, `rp_len`=0, no `rp_byte_en`.
- SETUP token 2D 00 10 → `rp_okay`=1, `rp_pid`=D, `rp_addr`=0, `rp_endp`=0. Same token with last byte 11 → `rp_okay`=0.
- DATA0 C3 80 06 00 01 00 00 40 00 DD 94 → 8 strobes with bytes 80 06 00 01 00 00 40 00, then `rp_fin` with `rp_okay`=1, `rp_len`=8. Same packet with byte 40 flipped to 41 → same 8 strobes, `rp_okay`=0.
- Zero-length DATA1 4B 00 00 → no strobes, `rp_okay`=1, `rp_len`=0. DATA0 C3 with a 1-byte body → `rp_okay`=0.
- Bad PID D3, and a truncated packet D2 plus 3 extra bits → each gives `rp_okay`=0.
- `rx_sta` after 2 data bytes, then a valid ACK → exactly one `rp_fin`, for the ACK with `rp_okay`=1. Assert `rst` mid-DATA0 → no `rp_fin`; the next valid packet decodes correctly.
